token_stepper: RTL and testbench

- Consumer end of the dice-roll interface for one player token.
- Accepts a roll over a valid/ready handshake and walks the token one square at a time at an animation rate.
- Applies any snake/ladder jump from a fixed board table, then reports completion.
- Sits between a dice source and the turn controller/display. One instance per player.

---
 rtl/token_stepper_if.sv | 19 +
 rtl/token_stepper.sv | 146 ++++++++++++++
 tb/tb_token_stepper.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/token_stepper_if.sv
// Dice-roll handshake between a dice source and a token stepper.
// The sender holds roll steady while roll_valid is high and roll_ready is low.
interface token_stepper_if;
    logic       roll_valid;
    logic [2:0] roll;
    logic       roll_ready;

    modport master (
        output roll_valid,
        output roll,
        input  roll_ready
    );

    modport slave (
        input  roll_valid,
        input  roll,
        output roll_ready
    );
endinterface

// File: rtl/token_stepper.sv
// One player's token: accepts a roll, steps square by square at the
// animation rate, applies any snake/ladder jump, then reports completion.
module token_stepper #(
    parameter int BOARD_MAX = 100,
    parameter int STEP_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    token_stepper_if.slave   rif,
    output logic [6:0]       position,
    output logic             moving,
    output logic             jump_taken,
    output logic             bad_roll,
    output logic             move_done,
    output logic             won
);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        CHECK,
        JUMP,
        DONE
    } state_t;

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    state_t         state;
    state_t         state_n;
    logic [DW-1:0]  div;
    logic [2:0]     remaining;
    logic           bad_q;

    logic           accept;
    logic           illegal;
    logic [7:0]     sum;
    logic           over;
    logic           tc;
    logic           hit;
    logic [6:0]     dest;

    assign rif.roll_ready = (state == IDLE) && !won && !reset;

    assign accept  = rif.roll_valid && rif.roll_ready;
    assign illegal = (rif.roll == 3'd0) || (rif.roll == 3'd7);
    // 8-bit sum so a move past square 127 cannot wrap into a legal square
    assign sum     = {1'b0, position} + {5'b0, rif.roll};
    assign over    = sum > 8'(BOARD_MAX);
    assign tc      = (div == DW'(STEP_DIV - 1));

    // Snake/ladder board table; misses leave the square unchanged
    always_comb begin
        hit  = 1'b1;
        dest = position;
        unique case (position)
            7'd3:    dest = 7'd22;
            7'd5:    dest = 7'd8;
            7'd11:   dest = 7'd26;
            7'd20:   dest = 7'd29;
            7'd28:   dest = 7'd84;
            7'd71:   dest = 7'd91;
            7'd17:   dest = 7'd4;
            7'd54:   dest = 7'd34;
            7'd62:   dest = 7'd19;
            7'd87:   dest = 7'd24;
            7'd98:   dest = 7'd79;
            default: hit  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal || over) state_n = DONE;
                    else                 state_n = STEP;
                end
            end
            STEP: begin
                if (tc && remaining == 3'd1) state_n = CHECK;
            end
            CHECK:   state_n = hit ? JUMP : DONE;
            JUMP:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Position, step divider and per-roll bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position  <= '0;
            remaining <= '0;
            div       <= '0;
            bad_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        remaining <= rif.roll;
                        div       <= '0;
                        bad_q     <= illegal;
                    end
                end
                STEP: begin
                    if (tc) begin
                        div       <= '0;
                        position  <= position + 7'd1;
                        remaining <= remaining - 3'd1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                JUMP:    position <= dest;
                default: ;
            endcase
        end
    end

    // Registered status outputs; won is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            moving     <= 1'b0;
            jump_taken <= 1'b0;
            bad_roll   <= 1'b0;
            move_done  <= 1'b0;
            won        <= 1'b0;
        end else begin
            moving     <= (state_n == STEP) || (state_n == CHECK) ||
                          (state_n == JUMP);
            jump_taken <= (state == JUMP);
            move_done  <= (state == DONE);
            bad_roll   <= (state == DONE) && bad_q;
            if (state == DONE && position == 7'(BOARD_MAX)) won <= 1'b1;
        end
    end

endmodule

// File: tb/tb_token_stepper.sv
// Randomized bench for token_stepper against a rule-level reference model.
// Tracks expected square, jump, illegal-roll and timing per accepted roll.
module tb_token_stepper;

    localparam int BMAX = 100;
    localparam int SDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] position;
    logic       moving;
    logic       jump_taken;
    logic       bad_roll;
    logic       move_done;
    logic       won;

    int n_tot  = 0;
    int n_pass = 0;
    int mpos   = 0;
    bit mwon   = 1'b0;

    token_stepper_if rif();

    token_stepper #(.BOARD_MAX(BMAX), .STEP_DIV(SDIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .rif        (rif),
        .position   (position),
        .moving     (moving),
        .jump_taken (jump_taken),
        .bad_roll   (bad_roll),
        .move_done  (move_done),
        .won        (won)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int board(input int p);
        case (p)
            3:  return 22;
            5:  return 8;
            11: return 26;
            20: return 29;
            28: return 84;
            71: return 91;
            17: return 4;
            54: return 34;
            62: return 19;
            87: return 24;
            98: return 79;
            default: return p;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rif.roll_valid = 1'b0;
        rif.roll = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos", position, 0);
        chk("rst_ready", rif.roll_ready, 0);
        chk("rst_flags", {moving, jump_taken, bad_roll, move_done, won}, 0);
        @(negedge clk);
        reset = 1'b0;
        mpos = 0;
        mwon = 1'b0;
    endtask

    // One accepted roll, checked against the model from the T0 edge onward
    task automatic do_roll(input int r);
        int  pos0, fin, lat, w, done_k, nj, nb;
        bit  bad, over, jmp, mv;
        pos0 = mpos;
        bad  = (r == 0) || (r == 7);
        over = !bad && (pos0 + r > BMAX);
        fin  = (bad || over) ? pos0 : board(pos0 + r);
        jmp  = !bad && !over && (fin != pos0 + r);
        lat  = (bad || over) ? 1 : r * SDIV + 2 + int'(jmp);
        w = 0;
        @(negedge clk);
        while (!rif.roll_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready", rif.roll_ready, 1);
        rif.roll_valid = 1'b1;
        rif.roll = 3'(r);
        @(posedge clk);
        #1;
        rif.roll_valid = 1'b0;
        done_k = -1;
        nj = 0;
        nb = 0;
        mv = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (moving) mv = 1'b1;
            if (jump_taken) nj++;
            if (bad_roll) begin
                nb++;
                chk("bad_with_done", move_done, 1);
            end
            if (!bad && !over && k % SDIV == 0 && k / SDIV <= r)
                chk("step_pos", position, pos0 + k / SDIV);
            if (move_done) begin
                done_k = k;
                break;
            end
        end
        chk("latency", done_k, lat);
        chk("final_pos", position, fin);
        chk("jumps", nj, int'(jmp));
        chk("bad_pulse", nb, int'(bad));
        chk("moving_seen", int'(mv), int'(!bad && !over));
        mpos = fin;
        if (fin == BMAX) mwon = 1'b1;
        chk("won", won, int'(mwon));
        @(posedge clk);
        #1;
        chk("done_1cyc", move_done, 0);
        chk("idle_ready", rif.roll_ready, int'(!mwon));
    endtask

    initial begin
        int  r;
        int  n;
        bit  extra;
        rif.roll_valid = 1'b0;
        rif.roll = 3'd0;

        do_reset();
        do_roll(2);
        do_reset();
        do_roll(3);
        do_roll(0);
        do_roll(7);

        // Abort mid-step: two squares into a roll of 6
        do_reset();
        @(negedge clk);
        rif.roll_valid = 1'b1;
        rif.roll = 3'd6;
        @(posedge clk);
        #1;
        rif.roll_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_pos", position, 2);
        reset = 1'b1;
        #1;
        chk("abort_pos", position, 0);
        chk("abort_moving", moving, 0);
        extra = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (move_done) extra = 1'b1;
        end
        chk("abort_nodone", int'(extra), 0);
        @(negedge clk);
        reset = 1'b0;
        mpos = 0;
        do_roll(1);

        // Random games; most rolls legal, some illegal
        for (int g = 0; g < 5; g++) begin
            do_reset();
            n = 0;
            while (!mwon && n < 250) begin
                r = $urandom_range(0, 11);
                if (r > 7) r = $urandom_range(1, 6);
                do_roll(r);
                n++;
            end
            if (mwon) begin
                @(negedge clk);
                rif.roll_valid = 1'b1;
                rif.roll = 3'd1;
                extra = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (rif.roll_ready || move_done || moving) extra = 1'b1;
                end
                rif.roll_valid = 1'b0;
                chk("won_locked", int'(extra), 0);
                chk("won_pos", position, BMAX);
                chk("won_sticky", won, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
